// File: rtl/fb_pkg.sv
// Shared constants, sizing helpers and write-FSM state type for the frame buffer.
package fb_pkg;
    localparam int H_RES_DEF = 640;
    localparam int V_RES_DEF = 480;

    typedef enum logic {
        WR_IDLE,
        WR_WRITE
    } wr_state_e;

    function automatic int frame_pix(input int h, input int v);
        return h * v;
    endfunction

    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction
endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port, read-first.
module sdp_ram
    import fb_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH = 16,
    localparam int AW = addr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // No reset on the array or read register so this maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
        if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/frame_buffer_dp.sv
// Frame buffer with auto-incrementing capture write port, random-access read
// port and optional ping-pong banking with reader-deferred swap.
module frame_buffer_dp
    import fb_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int H_RES = H_RES_DEF,
    parameter int V_RES = V_RES_DEF,
    parameter int DOUBLE_BUF = 1,
    localparam int FRAME_PIX = frame_pix(H_RES, V_RES),
    localparam int ADDR_W = addr_w(FRAME_PIX)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_sof,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_frame_done,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_lock,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              frame_valid,
    output logic [7:0]        frame_drop_cnt
);
    localparam int DEPTH = (DOUBLE_BUF != 0) ? 2 * FRAME_PIX : FRAME_PIX;
    localparam int RAM_AW = addr_w(DEPTH);
    localparam logic [RAM_AW-1:0] BANK1_BASE = RAM_AW'(FRAME_PIX);
    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(FRAME_PIX - 1);
    localparam logic [ADDR_W:0] FRAME_PIX_X = (ADDR_W + 1)'(FRAME_PIX);

    wr_state_e         state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, wr_idx;
    logic              ram_we, complete, wr_done_q;
    logic              wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
    logic              pend_q, pend_d, fv_q, fv_d;
    logic [7:0]        drop_q, drop_d;
    logic              rd_valid_q, rd_zero_q, rd_in_range, rd_bank_use;
    logic [RAM_AW-1:0] ram_waddr, ram_raddr;
    logic [DATA_W-1:0] ram_rdata;

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        wr_idx   = wr_ptr_q;
        ram_we   = 1'b0;
        complete = 1'b0;
        if (wr_sof) begin
            // Start of frame always restarts, abandoning any partial frame.
            state_d  = WR_WRITE;
            wr_ptr_d = '0;
            wr_idx   = '0;
            if (wr_valid) begin
                ram_we   = 1'b1;
                wr_ptr_d = ADDR_W'(1);
            end
        end else if (state_q == WR_WRITE && wr_valid) begin
            ram_we = 1'b1;
            if (wr_ptr_q == LAST_PIX) begin
                complete = 1'b1;
                state_d  = WR_IDLE;
                wr_ptr_d = '0;
            end else begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
        end
    end

    always_comb begin
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        pend_d    = pend_q;
        fv_d      = fv_q;
        drop_d    = drop_q;
        if (DOUBLE_BUF == 0) begin
            if (complete) fv_d = 1'b1;
        end else if (wr_sof && pend_q) begin
            // Pending frame sits in wr_bank and is about to be overwritten.
            pend_d = 1'b0;
            drop_d = sat_inc8(drop_q);
        end else if (complete || (pend_q && !rd_lock)) begin
            if (complete && pend_q) drop_d = sat_inc8(drop_q);
            if (rd_lock) begin
                pend_d = 1'b1;
            end else begin
                rd_bank_d = wr_bank_q;
                wr_bank_d = ~wr_bank_q;
                fv_d      = 1'b1;
                pend_d    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= WR_IDLE;
            wr_ptr_q   <= '0;
            wr_done_q  <= 1'b0;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b1;
            pend_q     <= 1'b0;
            fv_q       <= 1'b0;
            drop_q     <= '0;
            rd_valid_q <= 1'b0;
            rd_zero_q  <= 1'b1;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            wr_done_q  <= complete;
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            pend_q     <= pend_d;
            fv_q       <= fv_d;
            drop_q     <= drop_d;
            rd_valid_q <= rd_en;
            if (rd_en) rd_zero_q <= !rd_in_range;
        end
    end

    // Bank base is added, not concatenated, so FRAME_PIX need not be a power of two.
    assign rd_in_range = {1'b0, rd_addr} < FRAME_PIX_X;
    assign rd_bank_use = (DOUBLE_BUF != 0) && rd_bank_q;
    assign ram_waddr   = (wr_bank_q ? BANK1_BASE : '0) + RAM_AW'(wr_idx);
    assign ram_raddr   = (rd_bank_use ? BANK1_BASE : '0) + RAM_AW'(rd_addr);

    sdp_ram #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk    (clk),
        .we_i   (ram_we),
        .waddr_i(ram_waddr),
        .wdata_i(wr_data),
        .re_i   (rd_en && rd_in_range),
        .raddr_i(ram_raddr),
        .rdata_o(ram_rdata)
    );

    // The RAM register has no reset; the zero flag forces reset and out-of-range output to 0.
    assign rd_data        = rd_zero_q ? '0 : ram_rdata;
    assign rd_valid       = rd_valid_q;
    assign wr_frame_done  = wr_done_q;
    assign frame_valid    = fv_q;
    assign frame_drop_cnt = drop_q;
endmodule

// File: tb/tb_frame_buffer_dp.sv
// Scoreboard bench: 4x2 double-buffered instance for the main scenarios and a
// 3x3 instance whose 4-bit read address can express out-of-range indices.
module tb_frame_buffer_dp;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       wr_sof = 1'b0, wr_valid = 1'b0, rd_en = 1'b0, rd_lock = 1'b0;
    logic [7:0] wr_data = '0;
    logic [2:0] rd_addr = '0;
    logic       wr_frame_done, rd_valid, frame_valid;
    logic [7:0] rd_data, frame_drop_cnt;

    logic       wr_sof2 = 1'b0, wr_valid2 = 1'b0, rd_en2 = 1'b0;
    logic [7:0] wr_data2 = '0;
    logic [3:0] rd_addr2 = '0;
    logic       wr_frame_done2, rd_valid2, frame_valid2;
    logic [7:0] rd_data2, frame_drop_cnt2;

    int         n_chk = 0, n_pass = 0, done_cnt = 0, d0;
    logic [7:0] exp_q[$], exp2_q[$];

    frame_buffer_dp #(.DATA_W(8), .H_RES(4), .V_RES(2), .DOUBLE_BUF(1)) dut (
        .clk(clk), .rst_n(rst_n), .wr_sof(wr_sof), .wr_valid(wr_valid), .wr_data(wr_data),
        .wr_frame_done(wr_frame_done), .rd_en(rd_en), .rd_addr(rd_addr), .rd_lock(rd_lock),
        .rd_data(rd_data), .rd_valid(rd_valid), .frame_valid(frame_valid),
        .frame_drop_cnt(frame_drop_cnt)
    );

    frame_buffer_dp #(.DATA_W(8), .H_RES(3), .V_RES(3), .DOUBLE_BUF(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .wr_sof(wr_sof2), .wr_valid(wr_valid2), .wr_data(wr_data2),
        .wr_frame_done(wr_frame_done2), .rd_en(rd_en2), .rd_addr(rd_addr2), .rd_lock(1'b0),
        .rd_data(rd_data2), .rd_valid(rd_valid2), .frame_valid(frame_valid2),
        .frame_drop_cnt(frame_drop_cnt2)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    function automatic logic [7:0] px(input logic [7:0] base, input int i);
        return base + 8'(i);
    endfunction

    // Monitor: pops an expectation whenever a read result is presented.
    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_frame_done) done_cnt++;
            if (rd_valid) begin
                if (exp_q.size() == 0) check("rd_unexpected_valid", rd_valid, 1'b0);
                else check("rd_data", rd_data, exp_q.pop_front());
            end
            if (rd_valid2) begin
                if (exp2_q.size() == 0) check("rd2_unexpected_valid", rd_valid2, 1'b0);
                else check("rd2_data", rd_data2, exp2_q.pop_front());
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic sof, input logic vld, input logic [7:0] d,
                        input logic ren, input logic [2:0] ra, input logic [7:0] ex);
        wr_sof = sof; wr_valid = vld; wr_data = d; rd_en = ren; rd_addr = ra;
        if (ren) exp_q.push_back(ex);
        cyc();
        wr_sof = 1'b0; wr_valid = 1'b0; rd_en = 1'b0;
    endtask

    task automatic step2(input logic sof, input logic vld, input logic [7:0] d,
                         input logic ren, input logic [3:0] ra, input logic [7:0] ex);
        wr_sof2 = sof; wr_valid2 = vld; wr_data2 = d; rd_en2 = ren; rd_addr2 = ra;
        if (ren) exp2_q.push_back(ex);
        cyc();
        wr_sof2 = 1'b0; wr_valid2 = 1'b0; rd_en2 = 1'b0;
    endtask

    task automatic write_frame(input logic [7:0] base);
        for (int i = 0; i < 8; i++) step(i == 0, 1'b1, px(base, i), 1'b0, 3'd0, 8'h00);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #10;
        check("rst_rd_data", rd_data, 8'h00);
        check("rst_rd_valid", rd_valid, 1'b0);
        check("rst_done", wr_frame_done, 1'b0);
        check("rst_frame_valid", frame_valid, 1'b0);
        check("rst_drop", frame_drop_cnt, 8'h00);
        cyc(); rst_n = 1'b1; cyc();

        // Basic frame
        for (int i = 0; i < 7; i++) step(i == 0, 1'b1, px(8'h10, i), 1'b0, 3'd0, 8'h00);
        check("s1_fv_before_last", frame_valid, 1'b0);
        check("s1_done_before_last", wr_frame_done, 1'b0);
        step(1'b0, 1'b1, 8'h17, 1'b0, 3'd0, 8'h00);
        check("s1_done_pulse", wr_frame_done, 1'b1);
        check("s1_frame_valid", frame_valid, 1'b1);
        cyc();
        check("s1_done_single", wr_frame_done, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 3'(i), px(8'h10, i));

        // Ping-pong: reads stay on A until the edge that completes B
        write_frame(8'hA0);
        step(1'b0, 1'b0, 8'h00, 1'b1, 3'd3, 8'hA3);
        for (int i = 0; i < 8; i++) step(i == 0, 1'b1, px(8'hB0, i), 1'b1, 3'(i), px(8'hA0, i));
        check("s2_done_b", wr_frame_done, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1, 3'd0, 8'hB0);
        step(1'b0, 1'b0, 8'h00, 1'b1, 3'd7, 8'hB7);

        // Lock deferral
        rd_lock = 1'b1;
        for (int i = 0; i < 8; i++) step(i == 0, 1'b1, px(8'hD0, i), 1'b1, 3'(i), px(8'hB0, i));
        step(1'b0, 1'b0, 8'h00, 1'b1, 3'd3, 8'hB3);
        check("s3_drop_locked", frame_drop_cnt, 8'h00);
        rd_lock = 1'b0;
        step(1'b0, 1'b0, 8'h00, 1'b1, 3'd2, 8'hB2);
        step(1'b0, 1'b0, 8'h00, 1'b1, 3'd2, 8'hD2);
        check("s3_drop_after", frame_drop_cnt, 8'h00);

        // Drop: E completes under lock, F's sof overwrites it
        rd_lock = 1'b1;
        write_frame(8'hE0);
        step(1'b0, 1'b0, 8'h00, 1'b1, 3'd4, 8'hD4);
        check("s4_drop_pending", frame_drop_cnt, 8'h00);
        step(1'b1, 1'b1, 8'hF0, 1'b1, 3'd5, 8'hD5);
        check("s4_drop_inc", frame_drop_cnt, 8'h01);
        rd_lock = 1'b0;
        step(1'b0, 1'b1, 8'hF1, 1'b1, 3'd1, 8'hD1);
        for (int i = 2; i < 8; i++) step(1'b0, 1'b1, px(8'hF0, i), 1'b1, 3'd6, 8'hD6);
        step(1'b0, 1'b0, 8'h00, 1'b1, 3'd0, 8'hF0);
        step(1'b0, 1'b0, 8'h00, 1'b1, 3'd7, 8'hF7);
        check("s4_drop_final", frame_drop_cnt, 8'h01);

        // Abort then full frame
        d0 = done_cnt;
        for (int i = 0; i < 3; i++) step(i == 0, 1'b1, px(8'h50, i), 1'b0, 3'd0, 8'h00);
        write_frame(8'h60);
        cyc();
        check("s5_one_done", done_cnt - d0, 1);
        step(1'b0, 1'b0, 8'h00, 1'b1, 3'd0, 8'h60);
        step(1'b0, 1'b0, 8'h00, 1'b1, 3'd2, 8'h62);
        step(1'b0, 1'b0, 8'h00, 1'b1, 3'd7, 8'h67);
        cyc();
        check("s5_hold_valid", rd_valid, 1'b0);
        check("s5_hold_data", rd_data, 8'h67);

        // Out-of-range reads on the 9-pixel instance
        for (int i = 0; i < 9; i++) step2(i == 0, 1'b1, px(8'hC0, i), 1'b0, 4'd0, 8'h00);
        check("oob_frame_valid", frame_valid2, 1'b1);
        step2(1'b0, 1'b0, 8'h00, 1'b1, 4'd0, 8'hC0);
        step2(1'b0, 1'b0, 8'h00, 1'b1, 4'd9, 8'h00);
        step2(1'b0, 1'b0, 8'h00, 1'b1, 4'd8, 8'hC8);
        step2(1'b0, 1'b0, 8'h00, 1'b1, 4'd15, 8'h00);

        // Reset in the middle of a frame
        for (int i = 0; i < 3; i++) step(i == 0, 1'b1, px(8'h70, i), 1'b0, 3'd0, 8'h00);
        step(1'b0, 1'b0, 8'h00, 1'b1, 3'd1, 8'h61);
        #6 rst_n = 1'b0;
        #1;
        check("rst2_rd_data", rd_data, 8'h00);
        check("rst2_rd_valid", rd_valid, 1'b0);
        check("rst2_frame_valid", frame_valid, 1'b0);
        check("rst2_drop", frame_drop_cnt, 8'h00);
        check("rst2_done", wr_frame_done, 1'b0);
        cyc(); rst_n = 1'b1; cyc();
        d0 = done_cnt;
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'h99, 1'b0, 3'd0, 8'h00);
        cyc();
        check("s6_no_sof_fv", frame_valid, 1'b0);
        check("s6_no_sof_done", done_cnt - d0, 0);
        write_frame(8'h30);
        check("s6_frame_valid", frame_valid, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1, 3'd5, 8'h35);

        cyc(); cyc();
        check("sb_empty", exp_q.size(), 0);
        check("sb2_empty", exp2_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
